// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants and output-stage state type, used by both FIFO sides.
package fifo_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int PTR_W  = ADDR_W + 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;
endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping FIFO pointer register with occupancy/empty/almost-empty compare against the peer pointer.
// RD_SIDE selects which pointer is subtracted so the same block serves the write side.
module fifo_ptr_cnt #(
  parameter int ADDR_W    = fifo_pkg::ADDR_W,
  parameter int AE_THRESH = 1,
  parameter bit RD_SIDE   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  input  logic [ADDR_W:0] peer_ptr_i,
  output logic [ADDR_W:0] ptr_o,
  output logic [ADDR_W:0] count_o,
  output logic            empty_o,
  output logic            almost_empty_o
);
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] AE_L = PTR_W'(AE_THRESH);

  logic [ADDR_W:0] ptr_q, ptr_d;

  // Natural modulo-2^PTR_W wrap carries rd_addr 1023 -> 0 into the wrap bit.
  assign ptr_d = inc_i ? ptr_q + PTR_W'(1) : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o          = ptr_q;
  assign count_o        = RD_SIDE ? (peer_ptr_i - ptr_q) : (ptr_q - peer_ptr_i);
  assign empty_o        = (peer_ptr_i == ptr_q);
  assign almost_empty_o = (count_o <= AE_L);
endmodule

// File: rtl/fifo_rd_ctrl1024.sv
// Read-side controller for a 1024-entry single-clock FIFO: pointer, registered output word, underflow.
// Define FIFO_RD_FWFT_EN for first-word-fall-through; default is standard latency-1 reads.
module fifo_rd_ctrl1024 #(
  parameter int ADDR_W    = fifo_pkg::ADDR_W,
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              rd_req,
  input  logic              underflow_clr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              underflow
);
  import fifo_pkg::*;

  logic              load;
  logic              uf_set;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              underflow_q, underflow_d;

  fifo_ptr_cnt #(
    .ADDR_W   (ADDR_W),
    .AE_THRESH(AE_THRESH),
    .RD_SIDE  (1'b1)
  ) u_ptr (
    .clk           (clk),
    .rst           (rst),
    .inc_i         (load),
    .peer_ptr_i    (wr_ptr),
    .ptr_o         (rd_ptr),
    .count_o       (count),
    .empty_o       (empty),
    .almost_empty_o(almost_empty)
  );

`ifdef FIFO_RD_FWFT_EN
  out_state_e state_q, state_d;

  // The output register prefetches the head word; rd_req pops it.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      OUT_EMPTY: if (!empty) begin
        load    = 1'b1;
        state_d = OUT_VALID;
      end
      OUT_VALID: if (rd_req) begin
        if (!empty) load    = 1'b1;
        else        state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  assign uf_set     = rd_req && (state_q != OUT_VALID);
  assign data_valid = (state_q == OUT_VALID);

  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end
`else
  logic data_valid_q;

  assign load   = rd_req && !empty;
  assign uf_set = rd_req && empty;

  always_ff @(posedge clk) begin
    if (rst) data_valid_q <= 1'b0;
    else     data_valid_q <= load;
  end

  assign data_valid = data_valid_q;
`endif

  assign data_out_d  = load ? mem_rd_data : data_out_q;
  // Clear beats a same-cycle set so software never loses its acknowledge.
  assign underflow_d = underflow_clr ? 1'b0 : (uf_set ? 1'b1 : underflow_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_addr   = rd_ptr[ADDR_W-1:0];
  assign data_out  = data_out_q;
  assign underflow = underflow_q;
endmodule

// File: doc/fifo_rd_ctrl1024.md
FIFO_RD_CTRL1024 -- requirements
Module: fifo_rd_ctrl1024

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, storage address width (1024 entries).
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have parameter AE_THRESH, default 1, almost-empty threshold in words.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 SHALL have port clk, input, 1, sole clock, all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_ptr, input, ADDR_W+1, write pointer from the write side, with bit ADDR_W as the wrap bit.
REQ-008 SHALL have port mem_rd_data, input, DATA_W, combinational storage read data at rd_addr.
REQ-009 SHALL have port rd_req, input, 1, consumer read request (pop in FWFT mode).
REQ-010 SHALL have port underflow_clr, input, 1, clears the sticky underflow flag.
REQ-011 SHALL have port rd_addr, output, ADDR_W, equal to rd_ptr[ADDR_W-1:0], driving the storage read port.
REQ-012 SHALL have port rd_ptr, output, ADDR_W+1, read pointer returned to the write side for full detection.
REQ-013 SHALL have port data_out, output, DATA_W, registered read word.
REQ-014 SHALL have port data_valid, output, 1, data_out holds a valid word.
REQ-015 SHALL have port empty, output, 1, storage holds no unread words.
REQ-016 SHALL have port almost_empty, output, 1, count <= AE_THRESH.
REQ-017 SHALL have port count, output, ADDR_W+1, unread words in storage (0..1024).
REQ-018 SHALL have port underflow, output, 1, sticky read-when-empty error.

Function
REQ-019 SHALL compute count = (wr_ptr - rd_ptr) mod 2^(ADDR_W+1), combinationally.
REQ-020 SHALL assert empty iff wr_ptr == rd_ptr, and full detection is the write side's job.
REQ-021 SHALL increment rd_ptr by 1 per accepted read, wrapping 11'h7FF -> 11'h000; rd_addr 1023 -> 0 toggles the wrap bit.
REQ-022 SHALL, in standard mode on rd_req && !empty: capture mem_rd_data into data_out, advance rd_ptr, and assert data_valid the next cycle for exactly one cycle (latency 1).
REQ-023 SHALL, on rd_req && empty: leave rd_ptr unchanged, hold data_out, deassert data_valid, and set underflow.
REQ-024 SHALL allow back-to-back reads every cycle while !empty, with no bubble.
REQ-025 SHALL make a word written at cycle N readable in the cycle wr_ptr first reflects it, with no extra synchroniser (single clock).
REQ-026 SHALL give underflow_clr priority over a simultaneous underflow set (clear wins).
REQ-027 SHALL hold data_out when no read is accepted.

Reset
REQ-028 SHALL, on rst high at a clock edge, set rd_ptr=0, data_out=0, data_valid=0, underflow=0, and FSM=OUT_EMPTY, regardless of in-flight reads.
REQ-029 SHALL give rst priority over rd_req and underflow_clr in the same cycle.
REQ-030 SHALL have empty and count follow the reset rd_ptr and current wr_ptr combinationally; the write side resets wr_ptr in the same cycle.

Configuration
REQ-031 SHALL support macro FIFO_RD_FWFT_EN, which when defined enables first-word-fall-through mode.
REQ-032 SHALL, with FIFO_RD_FWFT_EN defined, use FSM states OUT_EMPTY and OUT_VALID; data_valid = (state == OUT_VALID).
REQ-033 SHALL, in FWFT state OUT_EMPTY with !empty, load data_out, advance rd_ptr, and move to OUT_VALID next cycle with no rd_req needed.
REQ-034 SHALL, in FWFT state OUT_VALID with rd_req: if !empty, reload and advance (stay OUT_VALID), else go to OUT_EMPTY.
REQ-035 SHALL, in FWFT mode, treat rd_req while data_valid=0 as an underflow.
REQ-036 SHALL, without FIFO_RD_FWFT_EN, implement the standard mode REQ-022..REQ-024 with no FSM.

Structure
REQ-037 SHALL take ADDR_W, DATA_W, PTR_W = ADDR_W+1, and the output-state typedef (OUT_EMPTY/OUT_VALID) from shared package fifo_pkg.
REQ-038 SHALL contain one sub-module, fifo_ptr_cnt: pointer register, increment/wrap, and count/empty/almost_empty compare, reusable by the write side.

Verification
REQ-039 SHALL verify: wr_ptr=3, rd_req high 3 cycles -> data_out = words 0,1,2 each one cycle later, then empty=1, count=0.
REQ-040 SHALL verify: rd_req with wr_ptr=rd_ptr=5 -> underflow=1, rd_ptr stays 5; underflow_clr and a new underflow in the same cycle -> underflow=0.
REQ-041 SHALL verify: rd_ptr=11'h3FF, wr_ptr=11'h401, 2 reads -> rd_addr 1023 then 0, final rd_ptr=11'h401, empty=1.
REQ-042 SHALL verify: wr_ptr=11'h400 with rd_ptr=0 -> count=1024, almost_empty=0; at count=1 -> almost_empty=1.
REQ-043 SHALL verify: rst asserted mid-burst -> next cycle rd_ptr=0, data_valid=0, data_out=0, underflow=0.
REQ-044 SHALL verify, with FIFO_RD_FWFT_EN: a write into an empty store -> data_valid=1 within one cycle with no rd_req; rd_req on the last word -> data_valid=0 next cycle.
